// File: rtl/mm_pkg.sv
// Shared matrix-multiply engine definitions: widths common to the vector-sum
// stage and the row collector, plus a constant-safe clog2.
package mm_pkg;

  localparam int N_COLS_DEF = 5;
  localparam int W_S_DEF    = 9;
  localparam int ROW_BANKS  = 2;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/dot_row_collector_if.sv
// Sum capture and row drain bus between vector-sum stage, collector and
// result writer.
interface dot_row_collector_if
  import mm_pkg::*;
#(
  parameter int N_COLS = N_COLS_DEF,
  parameter int W_s    = W_S_DEF
);
  logic [W_s-1:0]        sum;
  logic                  readEn;
  logic [N_COLS*W_s-1:0] row;
  logic                  row_valid;
  logic                  row_ready;

  modport master (output sum, readEn, row_ready, input row, row_valid);
  modport slave  (input sum, readEn, row_ready, output row, row_valid);
endinterface

// File: rtl/dot_row_collector_row_bank.sv
// One row buffer bank: N_COLS slots of W_s bits, slot 0 packed into the MS
// slice of the read-out.
module row_bank
  import mm_pkg::*;
#(
  parameter int N_COLS = N_COLS_DEF,
  parameter int W_s    = W_S_DEF
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       we_i,
  input  logic [clog2(N_COLS)-1:0]   slot_i,
  input  logic [W_s-1:0]             din_i,
  output logic [N_COLS*W_s-1:0]      row_o
);
  localparam int SW = clog2(N_COLS);

  logic [N_COLS-1:0][W_s-1:0] slots_q;

  // Slot s lives at packed index N_COLS-1-s so the array is already the row.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slots_q <= '0;
    end else if (we_i) begin
      for (int s = 0; s < N_COLS; s++)
        if (slot_i == SW'(s)) slots_q[N_COLS-1-s] <= din_i;
    end
  end

  assign row_o = slots_q;
endmodule

// File: rtl/dot_row_collector.sv
// Packs N_COLS consecutive dot-product sums into rows, ping-ponged across two
// banks and drained over a valid/ready handshake.
module dot_row_collector
  import mm_pkg::*;
#(
  parameter int N_COLS = N_COLS_DEF,
  parameter int W_s    = W_S_DEF
) (
  input  logic                      Clock,
  input  logic                      Reset_n,
  input  logic                      Clear,
  dot_row_collector_if.slave        bus,
  output logic                      overflow,
  output logic [clog2(N_COLS)-1:0]  col_idx
);
  localparam int CW = clog2(N_COLS);

  logic [CW-1:0] col_q, col_d;
  logic          wr_ptr_q, rd_ptr_q;
  logic [1:0]    count_q, count_d;
  logic          ovf_q;
  logic          cap, drop, last, drain;

  logic [ROW_BANKS-1:0][N_COLS*W_s-1:0] bank_row;

  // Fullness is judged on pre-edge count, so a same-edge drain cannot rescue
  // an arrival; Clear suppresses both capture and drop.
  assign cap   = bus.readEn && !Clear && (count_q != 2'd2);
  assign drop  = bus.readEn && !Clear && (count_q == 2'd2);
  assign last  = cap && (col_q == CW'(N_COLS-1));
  assign drain = (count_q != 2'd0) && bus.row_ready;

  always_comb begin
    col_d   = col_q;
    if (Clear)     col_d = '0;
    else if (last) col_d = '0;
    else if (cap)  col_d = col_q + CW'(1);
    count_d = count_q + {1'b0, last} - {1'b0, drain};
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      col_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      ovf_q    <= 1'b0;
    end else begin
      col_q   <= col_d;
      count_q <= count_d;
      if (last)  wr_ptr_q <= ~wr_ptr_q;
      if (drain) rd_ptr_q <= ~rd_ptr_q;
      if (drop)  ovf_q    <= 1'b1;
    end
  end

  for (genvar b = 0; b < ROW_BANKS; b++) begin : g_bank
    row_bank #(.N_COLS(N_COLS), .W_s(W_s)) u_bank (
      .clk_i  (Clock),
      .rst_ni (Reset_n),
      .we_i   (cap && (wr_ptr_q == 1'(b))),
      .slot_i (col_q),
      .din_i  (bus.sum),
      .row_o  (bank_row[b])
    );
  end

  assign bus.row       = bank_row[rd_ptr_q];
  assign bus.row_valid = (count_q != 2'd0);
  assign overflow      = ovf_q;
  assign col_idx       = col_q;
endmodule

// File: tb/tb_dot_row_collector.sv
// Directed plus randomized bench for dot_row_collector against a row-queue
// reference model.
module tb_dot_row_collector;
  localparam int N  = 5;
  localparam int W  = 9;
  localparam int RW = N * W;

  logic       Clock = 1'b0;
  logic       Reset_n = 1'b0;
  logic       Clear = 1'b0;
  logic       overflow;
  logic [2:0] col_idx;

  dot_row_collector_if #(.N_COLS(N), .W_s(W)) bus ();

  dot_row_collector #(.N_COLS(N), .W_s(W)) dut (
    .Clock    (Clock),
    .Reset_n  (Reset_n),
    .Clear    (Clear),
    .bus      (bus.slave),
    .overflow (overflow),
    .col_idx  (col_idx)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int failures = 0;

  // Reference model: completed rows waiting for the consumer, plus the row
  // currently being assembled.
  logic [RW-1:0] mq[$];
  logic [W-1:0]  part[N];
  int            mcol = 0;
  bit            mov = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [RW-1:0] pack_part();
    logic [RW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r = (r << W) | RW'(part[i]);
    return r;
  endfunction

  function automatic logic [RW-1:0] mk_row(input int a, b, c, d, e);
    return {W'(a), W'(b), W'(c), W'(d), W'(e)};
  endfunction

  task automatic model_reset();
    mq.delete();
    mcol = 0;
    mov  = 1'b0;
  endtask

  task automatic compare();
    chk("row_valid", 64'(bus.row_valid), 64'(mq.size() != 0));
    if (mq.size() != 0) chk("row", 64'(bus.row), 64'(mq[0]));
    chk("overflow", 64'(overflow), 64'(mov));
    chk("col_idx", 64'(col_idx), 64'(mcol));
  endtask

  task automatic step();
    bit full, drn;
    @(posedge Clock);
    full = (mq.size() == 2);
    drn  = (mq.size() != 0) && bus.row_ready;
    if (Clear) mcol = 0;
    else if (bus.readEn) begin
      if (full) mov = 1'b1;
      else begin
        part[mcol] = bus.sum;
        mcol++;
        if (mcol == N) begin
          mq.push_back(pack_part());
          mcol = 0;
        end
      end
    end
    if (drn) void'(mq.pop_front());
    #1;
    compare();
  endtask

  task automatic drive(input int s, input bit re, input bit rdy, input bit clr);
    bus.sum       = W'(s);
    bus.readEn    = re;
    bus.row_ready = rdy;
    Clear         = clr;
    step();
  endtask

  task automatic do_reset();
    bus.readEn = 1'b0; bus.row_ready = 1'b0; Clear = 1'b0;
    Reset_n = 1'b0;
    #1;
    model_reset();
    @(negedge Clock);
    Reset_n = 1'b1;
  endtask

  initial begin
    bus.sum = '0; bus.readEn = 1'b0; bus.row_ready = 1'b0;
    model_reset();
    #12;
    chk("rst_row", 64'(bus.row), 64'd0);
    compare();
    @(negedge Clock);
    Reset_n = 1'b1;

    // basic row
    drive(15, 1, 1, 0); drive(205, 1, 1, 0); drive(1, 1, 1, 0);
    drive(2, 1, 1, 0);  drive(3, 1, 1, 0);
    chk("basic_row", 64'(bus.row), 64'(mk_row(15, 205, 1, 2, 3)));
    chk("basic_valid", 64'(bus.row_valid), 64'd1);
    drive(0, 0, 1, 0);
    chk("basic_taken", 64'(bus.row_valid), 64'd0);

    // ping-pong back-pressure
    for (int i = 1; i <= 10; i++) drive(i, 1, 0, 0);
    chk("pp_row0", 64'(bus.row), 64'(mk_row(1, 2, 3, 4, 5)));
    chk("pp_ovf", 64'(overflow), 64'd0);
    drive(0, 0, 1, 0);
    chk("pp_row1", 64'(bus.row), 64'(mk_row(6, 7, 8, 9, 10)));
    drive(0, 0, 1, 0);

    // overflow with both banks full
    for (int i = 30; i < 40; i++) drive(i, 1, 0, 0);
    drive(77, 1, 0, 0);
    chk("ovf_set", 64'(overflow), 64'd1);
    drive(0, 0, 0, 0);
    drive(0, 0, 1, 0); drive(0, 0, 1, 0); drive(0, 0, 0, 0);
    chk("ovf_sticky", 64'(overflow), 64'd1);
    chk("ovf_col", 64'(col_idx), 64'd0);

    // same-edge drain and arrival with both banks full
    do_reset();
    for (int i = 40; i < 50; i++) drive(i, 1, 0, 0);
    drive(50, 1, 1, 0);
    chk("race_ovf", 64'(overflow), 64'd1);
    chk("race_col", 64'(col_idx), 64'd0);
    drive(51, 1, 0, 0);
    chk("race_slot0", 64'(col_idx), 64'd1);
    drive(0, 0, 1, 0); drive(0, 0, 1, 0);

    // clear aborts a partial row
    do_reset();
    drive(7, 1, 0, 0); drive(8, 1, 0, 0); drive(9, 1, 0, 0);
    drive(99, 1, 0, 1);
    chk("clr_col", 64'(col_idx), 64'd0);
    chk("clr_ovf", 64'(overflow), 64'd0);
    for (int i = 20; i < 25; i++) drive(i, 1, 1, 0);
    chk("clr_row", 64'(bus.row), 64'(mk_row(20, 21, 22, 23, 24)));
    drive(0, 0, 1, 0);

    // async reset mid-row with a full bank pending and overflow set
    for (int i = 0; i < 12; i++) drive(i + 100, 1, 0, 0);
    drive(1, 1, 0, 0); drive(2, 1, 0, 0);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("arst_valid", 64'(bus.row_valid), 64'd0);
    chk("arst_ovf", 64'(overflow), 64'd0);
    chk("arst_col", 64'(col_idx), 64'd0);
    chk("arst_row", 64'(bus.row), 64'd0);
    model_reset();
    bus.readEn = 1'b0; bus.row_ready = 1'b0;
    @(negedge Clock);
    Reset_n = 1'b1;

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if (n % 700 == 699) do_reset();
      drive(int'($urandom_range(0, 511)), ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 9) < 3), ($urandom_range(0, 39) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dot_row_collector.md
# dot_row_collector

Downstream stage of the vector-sum unit in the matrix-multiply engine. Captures each dot-product `sum` strobed by the adder's `readEn` and packs N_COLS consecutive results into one output-matrix row. Rows are held in a two-bank ping-pong buffer: one bank fills while the other drains over a valid/ready handshake to the result writer. The upstream adder has no back-pressure, so an arrival with both banks full is dropped and flagged.

## Interface
- N_COLS, 5: dot products per output row; ≥2.
- W_s, 9: width of one sum. Equals W_u + clog2(DIM) of the upstream adder.
- Clock  in  1  rising-edge clock for all state.
- Reset_n  in  1  asynchronous, active-low reset.
- sum  in  W_s  dot-product value from the vector-sum stage.
- readEn  in  1  `sum` valid this cycle; single-cycle strobe, may repeat back-to-back.
- Clear  in  1  synchronous abort of the partially filled row; full banks are kept.
- row  out  N_COLS*W_s  packed row; first-captured sum in the MS slice.
- row_valid  out  1  a full row is presented on `row`.
- row_ready  in  1  consumer accepts `row` when high together with `row_valid`.
- overflow  out  1  sticky: a sum was dropped. Cleared only by reset.
- col_idx  out  clog2(N_COLS)  column slot the next capture writes.

## Operation
- State:
  - 2 banks of N_COLS×W_s registers.
  - wr_ptr (1 b), rd_ptr (1 b), count (0..2 full banks).
  - col_idx counter.
  - overflow flag.
- Capture:
  - Fires when readEn=1 and count<2.
  - Writes `sum` into bank[wr_ptr], slot col_idx. Slot 0 is the MS slice, bits [N_COLS*W_s-1 -: W_s].
  - col_idx increments.
  - On the capture at col_idx=N_COLS-1: col_idx wraps to 0, wr_ptr toggles, the bank becomes full (count+1).
- Drop:
  - readEn=1 with count==2 at the sampling edge.
  - `sum` is discarded, overflow←1, col_idx unchanged.
  - This holds even if a handshake frees a bank on the same edge; the freed bank is usable from the next edge.
- Drain:
  - row = bank[rd_ptr]; row_valid = (count≠0).
  - On row_valid && row_ready: rd_ptr toggles, count−1.
- Simultaneous row completion and drain: count is unchanged, both pointers toggle.
- Clear:
  - col_idx←0. The partial data is abandoned; it is not zeroed and is overwritten by later captures.
  - If readEn is also 1, Clear wins and the sum is discarded. This is not an overflow.
- No arithmetic: values pass through bit-exact and unsigned.

## Timing
- Reset (async assert, sync release): count=0, wr_ptr=rd_ptr=0, col_idx=0, overflow=0, row_valid=0. Bank contents are reset to 0, so row=0.
- Latency: the last sum of a row sampled at edge k gives row_valid=1 and the complete `row` from edge k onward (1 cycle after the strobe cycle).
- `row` and `row_valid` are stable while row_valid && !row_ready.
- Throughput: one sum per cycle sustained while the consumer accepts one row per N_COLS cycles. With row_ready held low, 2·N_COLS sums are accepted before the first drop.
- row_ready while row_valid=0 is ignored.
- Reset mid-row or mid-handshake returns all state to reset values immediately.

## Structure
- Shared package `mm_pkg`:
  - `clog2` function.
  - `ROW_BANKS = 2` constant.
  - Default N_COLS and W_s, shared with the vector-sum stage.
- Sub-module `row_bank`: one N_COLS×W_s register bank with slot-write enable and packed read-out. Instantiated twice.
- Top level holds the pointers, counters, overflow and handshake logic.

## Test plan
- Basic row: N_COLS=5, W_s=9, reset, row_ready=1. Strobe 15, 205, 1, 2, 3 on consecutive cycles → one cycle after the last strobe, row_valid=1 and row = {9'd15, 9'd205, 9'd1, 9'd2, 9'd3}. The row is accepted that cycle, so row_valid=0 on the next cycle.
- Ping-pong back-pressure:
  - Hold row_ready=0 and send 10 sums 1..10 back-to-back → row_valid=1 with row={1,2,3,4,5}, overflow=0.
  - Then raise row_ready for 2 cycles → rows {1..5} then {6..10}.
- Overflow: with both banks full and row_ready=0, strobe sum=77 → overflow=1 and stays 1. After draining, 77 does not appear in any row, and col_idx is still 0.
- Edge race: with count==2, assert row_ready and readEn in the same cycle → the sum is dropped and overflow=1. A strobe in the next cycle lands in slot 0 of the freed bank.
- Clear: strobe 3 sums, assert Clear with readEn=1 → col_idx=0, overflow=0. The next 5 sums 20..24 give row={20,21,22,23,24}.
- Async reset: pulse Reset_n low mid-row with a full bank pending → row_valid, overflow and col_idx go to 0 without waiting for a clock edge.
